// File: rtl/pkg_cpu.sv
// rtl/pkg_cpu.sv - shared types and widths for the execute result stage
package pkg_cpu;

  localparam int CPU_WORD_WIDTH    = 32;
  localparam int CPU_REG_IDX_WIDTH = 4;
  localparam int FLAGS_WIDTH       = 4;

  // Bit position of each flag inside the flags vector (N is the MSB).
  typedef enum logic [1:0] {
    FlagN = 2'd3,
    FlagV = 2'd2,
    FlagZ = 2'd1,
    FlagC = 2'd0
  } flag_slot_e;

  // One pending ALU result, as held by the main and skid registers.
  typedef struct packed {
    logic [CPU_WORD_WIDTH-1:0]    result;
    logic [FLAGS_WIDTH-1:0]       flags;
    logic [CPU_REG_IDX_WIDTH-1:0] dst_reg;
    logic                         wr_reg;
    logic                         wr_flags;
  } StrcExecResult;

endpackage

// File: rtl/cpu_exec_fwd_mux.sv
// rtl/cpu_exec_fwd_mux.sv - priority bypass lookup over the main and skid entries
module cpu_exec_fwd_mux #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4
) (
  input  logic                     main_valid,
  input  logic                     main_wr_reg,
  input  logic [REG_IDX_WIDTH-1:0] main_dst_reg,
  input  logic [WORD_WIDTH-1:0]    main_result,
  input  logic                     skid_valid,
  input  logic                     skid_wr_reg,
  input  logic [REG_IDX_WIDTH-1:0] skid_dst_reg,
  input  logic [WORD_WIDTH-1:0]    skid_result,
  input  logic [REG_IDX_WIDTH-1:0] fwd_reg,
  output logic                     fwd_hit,
  output logic [WORD_WIDTH-1:0]    fwd_data
);

  logic main_match;
  logic skid_match;

  assign main_match = main_valid & main_wr_reg & (main_dst_reg == fwd_reg);
  assign skid_match = skid_valid & skid_wr_reg & (skid_dst_reg == fwd_reg);

  // Skid holds the younger result, so it wins over main.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (skid_match) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_result;
    end else if (main_match) begin
      fwd_hit  = 1'b1;
      fwd_data = main_result;
    end
  end

endmodule

// File: rtl/cpu_exec_result_stage.sv
// rtl/cpu_exec_result_stage.sv - ALU result skid buffer, flags register and bypass (CPU_EXEC_STAGE_FWD_EN enables bypass)
module cpu_exec_result_stage
  import pkg_cpu::*;
#(
  parameter int WORD_WIDTH    = pkg_cpu::CPU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH = pkg_cpu::CPU_REG_IDX_WIDTH,
  parameter int FLAGS_WIDTH   = pkg_cpu::FLAGS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    in_result,
  input  logic [FLAGS_WIDTH-1:0]   in_flags,
  input  logic [REG_IDX_WIDTH-1:0] in_dst_reg,
  input  logic                     in_wr_reg,
  input  logic                     in_wr_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_result,
  output logic [REG_IDX_WIDTH-1:0] out_dst_reg,
  output logic                     out_wr_reg,
  output logic [FLAGS_WIDTH-1:0]   flags_q,
  input  logic [REG_IDX_WIDTH-1:0] fwd_reg,
  output logic                     fwd_hit,
  output logic [WORD_WIDTH-1:0]    fwd_data
);

  StrcExecResult              main_q, main_d;
  StrcExecResult              skid_q, skid_d;
  StrcExecResult              in_entry;
  logic                       main_valid_q, main_valid_d;
  logic                       skid_valid_q, skid_valid_d;
  logic [FLAGS_WIDTH-1:0]     flags_d;
  logic                       accept;
  logic                       release_main;

  // in_ready depends only on stored state so there is no out_ready -> in_ready path.
  assign in_ready     = ~skid_valid_q;
  assign accept       = in_valid & in_ready;
  assign release_main = main_valid_q & out_ready;

  assign out_valid   = main_valid_q;
  assign out_result  = main_q.result;
  assign out_dst_reg = main_q.dst_reg;
  assign out_wr_reg  = main_q.wr_reg;

  // Pack the incoming ALU result into the stored entry format.
  always_comb begin
    in_entry          = '0;
    in_entry.result   = in_result;
    in_entry.flags    = in_flags;
    in_entry.dst_reg  = in_dst_reg;
    in_entry.wr_reg   = in_wr_reg;
    in_entry.wr_flags = in_wr_flags;
  end

  // Two-entry skid buffer next state; main always holds the oldest entry.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (release_main) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && release_main) begin
        main_d = in_entry;
      end else if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end else if (release_main) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end
  end

  // Flags commit at acceptance, independent of writeback stalls.
  always_comb begin
    flags_d = flags_q;
    if (accept && in_wr_flags) begin
      flags_d = in_flags;
    end
  end

  // State registers; reset drops any pending entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      flags_q      <= flags_d;
    end
  end

  // Flags travel with the entry only for symmetry; the flags register is the consumer.
  logic unused_main_bits;

`ifdef CPU_EXEC_STAGE_FWD_EN
  assign unused_main_bits = ^{main_q.flags, main_q.wr_flags};

  cpu_exec_fwd_mux #(
    .WORD_WIDTH    (WORD_WIDTH),
    .REG_IDX_WIDTH (REG_IDX_WIDTH)
  ) u_fwd_mux (
    .main_valid   (main_valid_q),
    .main_wr_reg  (main_q.wr_reg),
    .main_dst_reg (main_q.dst_reg),
    .main_result  (main_q.result),
    .skid_valid   (skid_valid_q),
    .skid_wr_reg  (skid_q.wr_reg),
    .skid_dst_reg (skid_q.dst_reg),
    .skid_result  (skid_q.result),
    .fwd_reg      (fwd_reg),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );
`else
  // Without bypass the pipeline must interlock on hazards upstream.
  assign unused_main_bits = ^{main_q.flags, main_q.wr_flags, fwd_reg};
  assign fwd_hit          = 1'b0;
  assign fwd_data         = '0;
`endif

endmodule

// File: tb/tb_cpu_exec_result_stage.sv
// tb/tb_cpu_exec_result_stage.sv - directed-vector bench for cpu_exec_result_stage
module tb_cpu_exec_result_stage;

`ifdef CPU_EXEC_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_dst_reg;
  logic        in_wr_reg;
  logic        in_wr_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_dst_reg;
  logic        out_wr_reg;
  logic [3:0]  flags_q;
  logic [3:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int n_vec;
  int n_miss;

  cpu_exec_result_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_dst_reg  (in_dst_reg),
    .in_wr_reg   (in_wr_reg),
    .in_wr_flags (in_wr_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dst_reg (out_dst_reg),
    .out_wr_reg  (out_wr_reg),
    .flags_q     (flags_q),
    .fwd_reg     (fwd_reg),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] dst,
                       input logic wr, input logic wf, input logic [3:0] fl);
    in_valid    = v;
    in_result   = res;
    in_dst_reg  = dst;
    in_wr_reg   = wr;
    in_wr_flags = wf;
    in_flags    = fl;
  endtask

  task automatic single_accept(input string pfx);
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00A5, 4'd3, 1'b1, 1'b1, 4'b0010);
    step();
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    chk({pfx, "_valid"}, 32'(out_valid), 32'd1);
    chk({pfx, "_result"}, out_result, 32'hA5);
    chk({pfx, "_dst"}, 32'(out_dst_reg), 32'd3);
    chk({pfx, "_wr_reg"}, 32'(out_wr_reg), 32'd1);
    chk({pfx, "_flags"}, 32'(flags_q), 32'b0010);
    step();
    chk({pfx, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    out_ready = 1'b0;
    fwd_reg   = 4'd0;
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    step();
    step();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dst", 32'(out_dst_reg), 32'd0);
    chk("rst_out_wr_reg", 32'(out_wr_reg), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    #2 rst = 1'b0;

    // Single accept
    single_accept("s1");

    // Back-to-back streaming, one result per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 4'(i), 1'b1, 1'b0, 4'b0);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_result", out_result, 32'(i));
    end
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    step();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Stall fills main then skid
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 4'd1, 1'b1, 1'b0, 4'b0);
    step();
    drive(1'b1, 32'h22, 4'd2, 1'b1, 1'b0, 4'b0);
    step();
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_result", out_result, 32'h11);
    step();
    chk("stall_hold_result", out_result, 32'h11);
    chk("stall_hold_dst", 32'(out_dst_reg), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("stall_no_comb_ready", 32'(in_ready), 32'd0);
    step();
    chk("skid_to_main_result", out_result, 32'h22);
    chk("skid_to_main_valid", 32'(out_valid), 32'd1);
    chk("skid_in_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Forwarding priority: skid (newer) wins over main
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 4'd5, 1'b1, 1'b0, 4'b0);
    step();
    drive(1'b1, 32'h20, 4'd5, 1'b1, 1'b0, 4'b0);
    step();
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    fwd_reg = 4'd5;
    #1;
    chk("fwd_r5_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
    chk("fwd_r5_data", fwd_data, FWD ? 32'h20 : 32'h0);
    fwd_reg = 4'd6;
    #1;
    chk("fwd_r6_hit", 32'(fwd_hit), 32'd0);
    chk("fwd_r6_data", fwd_data, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // Only main left: in_* with the same register must not be forwarded
    drive(1'b0, 32'h99, 4'd4, 1'b1, 1'b0, 4'b0);
    fwd_reg = 4'd4;
    #1;
    chk("fwd_in_not_fwd", 32'(fwd_hit), 32'd0);
    fwd_reg = 4'd5;
    #1;
    chk("fwd_main_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
    chk("fwd_main_data", fwd_data, FWD ? 32'h20 : 32'h0);
    out_ready = 1'b1;
    step();
    chk("fwd_drained", 32'(out_valid), 32'd0);

    // Flags commit on accept even while writeback is stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h33, 4'd7, 1'b0, 1'b1, 4'b1001);
    step();
    chk("flags_first", 32'(flags_q), 32'b1001);
    chk("flags_wr_reg0", 32'(out_wr_reg), 32'd0);
    drive(1'b1, 32'h44, 4'd8, 1'b1, 1'b0, 4'b0110);
    step();
    drive(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 4'b0);
    chk("flags_hold", 32'(flags_q), 32'b1001);
    chk("flags_stalled_valid", 32'(out_valid), 32'd1);
    chk("flags_full", 32'(in_ready), 32'd0);
    fwd_reg = 4'd7;
    #1;
    chk("fwd_wr_reg0_nohit", 32'(fwd_hit), 32'd0);

    // Asynchronous reset between edges while both entries are full
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_flags", 32'(flags_q), 32'd0);
    chk("arst_fwd_hit", 32'(fwd_hit), 32'd0);
    #1 rst = 1'b0;
    single_accept("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
